// File: rtl/inst_mem.sv
// Eight-entry instruction store with a registered fetch port and a byte-serial,
// valid/ready program loader that assembles big-endian words.
module inst_mem #(
  parameter int          DEPTH    = 8,
  parameter int          ADDR_W   = 3,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  output logic [31:0]       instruction,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              load_done,
  output logic              loading
);

  typedef enum logic {RUN, LOAD} state_t;

  localparam int SPAN = 1 << ADDR_W;

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [23:0]       shift_reg, shift_next;
  logic              commit;
  logic              done_next;
  logic [31:0]       commit_word;
  logic [31:0]       read_vec [SPAN];

  assign commit_word = {shift_reg, load_byte};

  // Addresses beyond DEPTH decode to NOP so the fetch mux is always full width.
  genvar gi;
  generate
    for (gi = 0; gi < SPAN; gi++) begin : g_word
      if (gi < DEPTH) begin : g_store
        logic [31:0] word_reg;
        always_ff @(posedge clk) begin
          if (rst) begin
            word_reg <= '0;
          end else if (commit && (ptr_reg == ADDR_W'(gi))) begin
            word_reg <= commit_word;
          end
        end
        assign read_vec[gi] = word_reg;
      end else begin : g_pad
        assign read_vec[gi] = NOP_WORD;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      ptr_reg     <= '0;
      shift_reg   <= '0;
      load_done   <= 1'b0;
      instruction <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
      shift_reg   <= shift_next;
      load_done   <= done_next;
      instruction <= (state_reg == LOAD) ? NOP_WORD : read_vec[address];
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    shift_next = shift_reg;
    commit     = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      RUN: begin
        if (load_start) begin
          state_next = LOAD;
          cnt_next   = '0;
          ptr_next   = '0;
          shift_next = '0;
        end
      end
      LOAD: begin
        // A restart wins over a byte presented in the same cycle.
        if (load_start) begin
          cnt_next   = '0;
          ptr_next   = '0;
          shift_next = '0;
        end else if (load_valid) begin
          shift_next = commit_word[23:0];
          if (cnt_reg == 2'd3) begin
            commit   = 1'b1;
            cnt_next = '0;
            if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
              ptr_next   = '0;
              state_next = RUN;
              done_next  = 1'b1;
            end else begin
              ptr_next = ptr_reg + ADDR_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + 2'd1;
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign load_ready = (state_reg == LOAD);
  assign loading    = (state_reg == LOAD);

endmodule

// File: doc/inst_mem.md
# inst_mem

Eight-entry, 32-bit instruction store that answers the processor's instruction fetch: the processor drives a 3-bit `address` and samples the returned `instruction`. Memory is filled at run time by a byte-serial loader port with a valid/ready handshake. Four bytes are assembled big-endian into one word. While a load is in progress, fetches return NOP.

## Interface

- `DEPTH`, 8: number of instruction words; must be ≤ 2^`ADDR_W`.
- `ADDR_W`, 3: fetch address width.
- `NOP_WORD`, 32'h0000_0000: word returned during load and for out-of-range addresses (opcode 0 decodes as NOP).

Ports:

- `clk`  in  1  single system clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `address`  in  `ADDR_W`  fetch address from the processor.
- `instruction`  out  32  registered fetch data.
- `load_start`  in  1  one-cycle pulse; begins a full-memory load.
- `load_valid`  in  1  `load_byte` is valid this cycle.
- `load_byte`  in  8  program byte, most-significant byte of each word first.
- `load_ready`  out  1  block accepts a byte this cycle.
- `load_done`  out  1  one-cycle pulse when the last word has been committed.
- `loading`  out  1  high while the state is LOAD.

## Operation

- States: RUN, LOAD.
- Reset (`rst`=1 at a clock edge):
  - all `DEPTH` words cleared to 0;
  - state RUN, byte counter 0, word pointer 0, shift register 0;
  - `instruction`=0, `load_ready`=0, `load_done`=0, `loading`=0.
- RUN:
  - each cycle `instruction` <= mem[`address`]; returns `NOP_WORD` if `address` ≥ `DEPTH`;
  - `load_valid` ignored; `load_ready`=0;
  - `load_start`=1 -> LOAD, byte counter 0, word pointer 0.
- LOAD:
  - `load_ready`=1, `loading`=1, `instruction` <= `NOP_WORD` each cycle;
  - byte accepted when `load_valid` && `load_ready`: shift reg <= {shift[23:0], `load_byte`}, byte counter +1;
  - on the 4th accepted byte (counter 3): mem[word pointer] <= {shift[23:0], `load_byte`}; counter wraps to 0; pointer +1;
  - when the committed word is at pointer `DEPTH`-1: pointer wraps to 0, `load_done` pulses the next cycle, state -> RUN.
- `load_start` while in LOAD restarts the load: counter and pointer go to 0 and the partial word is discarded. Words already committed stay in memory until overwritten. `load_start` has priority over a byte accepted in the same cycle; that byte is dropped.
- `rst` mid-load aborts the load: everything returns to its reset values and memory is cleared.
- No partial-load commit: fewer than 4·`DEPTH` bytes leaves the block in LOAD indefinitely.

## Timing

- Fetch latency is 1 cycle: a change on `address` at edge N appears on `instruction` after edge N+1.
- First RUN fetch after `load_done`: `instruction` shows mem[`address`] one cycle after the RUN transition. The cycle in which `load_done`=1 already performs a RUN read.
- Byte throughput is 1 byte/cycle while `load_valid` is held high. A full load takes 4·`DEPTH` accepted cycles (32 by default).
- `load_ready` is a function of state only; there is no combinational path from `load_valid` to `load_ready`.
- `load_done` and the LOAD -> RUN transition happen together, on the edge after the last byte is accepted.

## Test plan

- Reset, then `address`=0..7 with no load -> `instruction`=0 for every address, one cycle after each address change; `load_ready`=0.
- `load_start`, then 32 back-to-back bytes 8'h10,8'h00,8'h00,8'h05, 8'h20,8'h10,8'h00,8'h00, … -> `load_done` pulses exactly once, 1 cycle after byte 32. Afterwards `address`=0 gives 32'h1000_0005 and `address`=1 gives 32'h2010_0000.
- Fetch during LOAD, with `address`=1 held -> `instruction`=32'h0000_0000 throughout. After `load_done`, it shows the loaded word one cycle later.
- Gapped `load_valid` (random idle cycles between bytes) -> same memory contents as the back-to-back case; no byte is lost or duplicated.
- `load_start` re-asserted after 6 bytes, then 32 fresh bytes -> word 0 comes from the fresh bytes 0–3. No trace of the 2 partial bytes; `load_done` fires once.
- `rst` asserted after 10 bytes -> next cycle `loading`=0, `load_ready`=0, and all addresses read 0.
